aes_if: RTL and testbench

- Byte-wide, address-mapped host wrapper around an iterative AES-128/256 engine (FIPS-197).
- Host streams config, key and plaintext/ciphertext as 16-bit words, pulses init/next, polls status, then reads a 16-byte result.
- This block holds the registers, word counters and the address-decode FSM; the cipher datapath is the aes_core sub-module.

---
 rtl/aes_pkg.sv | 111 +++++++++++
 rtl/aes_core.sv | 126 ++++++++++++
 rtl/aes_if.sv | 110 +++++++++++
 tb/tb_aes_if.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared constants and GF(2^8)/round helpers for the AES host wrapper and core.
package aes_pkg;

    typedef enum logic [3:0] {
        ADDR_IDLE   = 4'd0,
        ADDR_CONFIG = 4'd1,
        ADDR_KEY    = 4'd2,
        ADDR_BLOCK  = 4'd3,
        ADDR_STATUS = 4'd5,
        ADDR_START  = 4'd6,
        ADDR_RESULT = 4'd7
    } aes_addr_e;

    typedef enum logic [1:0] {CS_IDLE, CS_KEYEXP, CS_ROUND} core_state_e;

    localparam int unsigned CONFIG_ENCDEC = 0;
    localparam int unsigned CONFIG_KEYLEN = 1;
    localparam int unsigned START_INIT    = 0;
    localparam int unsigned START_NEXT    = 1;
    localparam int unsigned STATUS_READY  = 0;
    localparam int unsigned STATUS_VALID  = 1;
    localparam logic        KEYLEN_128    = 1'b0;
    localparam logic        KEYLEN_256    = 1'b1;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // x^254 by square-and-multiply; maps 0 to 0 as the S-box requires
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p, r;
        p = a;
        r = 8'h01;
        for (int unsigned i = 1; i < 8; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int unsigned n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] i;
        i = gf_inv(x);
        return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] n);
        logic [7:0] r;
        r = 8'h01;
        for (int unsigned i = 1; i < 10; i++)
            if (i < int'(n)) r = xtime(r);
        return r;
    endfunction

    // Byte 4*c+r is row r of column c; byte 0 is the MSB of the state
    function automatic logic [127:0] sub_shift(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        logic [7:0]   b;
        int unsigned  src;
        o = '0;
        for (int unsigned c = 0; c < 4; c++)
            for (int unsigned r = 0; r < 4; r++) begin
                src = inv ? (c + 4 - r) % 4 : (c + r) % 4;
                b   = s[127 - 8*(4*src + r) -: 8];
                o[127 - 8*(4*c + r) -: 8] = inv ? inv_sbox(b) : sbox(b);
            end
        return o;
    endfunction

    function automatic logic [127:0] mix_cols(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        logic [7:0]   a [4];
        logic [7:0]   k [4];
        o = '0;
        if (inv) k = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     k = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) a[r] = s[127 - 8*(4*c + r) -: 8];
            for (int unsigned r = 0; r < 4; r++)
                o[127 - 8*(4*c + r) -: 8] = gmul(a[r], k[0]) ^ gmul(a[(r+1)%4], k[1]) ^
                                            gmul(a[(r+2)%4], k[2]) ^ gmul(a[(r+3)%4], k[3]);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_core.sv
// Iterative FIPS-197 engine: one expanded key word per cycle, then one round per cycle.
module aes_core
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         encdec,
    input  logic         keylen,
    input  logic         init,
    input  logic         next,
    input  logic [255:0] key,
    input  logic [127:0] block,
    output logic         key_ready,
    output logic [127:0] result,
    output logic         result_valid
);

    core_state_e  state_q, state_d;
    logic [31:0]  w_q [60];
    logic [5:0]   widx_q;
    logic [3:0]   round_q;
    logic         klen_q, enc_q, key_ready_q, result_valid_q;
    logic [127:0] st_q;

    logic [3:0]   nr, rk_round;
    logic [5:0]   last_w, rk_idx;
    logic [31:0]  t, new_w;
    logic [127:0] rk, round_out;
    logic         start_blk, key_done, blk_done;

    assign nr       = klen_q ? 4'd14 : 4'd10;
    assign last_w   = klen_q ? 6'd59 : 6'd43;
    assign rk_round = (state_q == CS_ROUND) ? round_q : (encdec ? 4'd0 : nr);
    assign rk_idx   = {rk_round, 2'b00};
    assign rk       = {w_q[rk_idx], w_q[rk_idx + 6'd1], w_q[rk_idx + 6'd2], w_q[rk_idx + 6'd3]};

    always_comb begin
        t = w_q[widx_q - 6'd1];
        if (klen_q ? (widx_q[2:0] == 3'd0) : (widx_q[1:0] == 2'd0))
            t = sub_word({t[23:0], t[31:24]}) ^
                {rcon(klen_q ? {1'b0, widx_q[5:3]} : widx_q[5:2]), 24'h0};
        else if (klen_q && widx_q[2:0] == 3'd4)
            t = sub_word(t);
        new_w = w_q[widx_q - (klen_q ? 6'd8 : 6'd4)] ^ t;

        if (enc_q) begin
            round_out = sub_shift(st_q, 1'b0);
            if (round_q != nr) round_out = mix_cols(round_out, 1'b0);
            round_out = round_out ^ rk;
        end else begin
            round_out = sub_shift(st_q, 1'b1) ^ rk;
            if (round_q != 4'd0) round_out = mix_cols(round_out, 1'b1);
        end
    end

    always_comb begin
        state_d   = state_q;
        start_blk = 1'b0;
        key_done  = 1'b0;
        blk_done  = 1'b0;
        if (init) begin
            state_d = CS_KEYEXP;
        end else begin
            case (state_q)
                CS_IDLE:
                    if (next && key_ready_q) begin
                        state_d   = CS_ROUND;
                        start_blk = 1'b1;
                    end
                CS_KEYEXP:
                    if (widx_q == last_w) begin
                        state_d  = CS_IDLE;
                        key_done = 1'b1;
                    end
                CS_ROUND:
                    if (enc_q ? (round_q == nr) : (round_q == 4'd0)) begin
                        state_d  = CS_IDLE;
                        blk_done = 1'b1;
                    end
                default: state_d = CS_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= CS_IDLE;
            widx_q         <= '0;
            round_q        <= '0;
            klen_q         <= 1'b0;
            enc_q          <= 1'b0;
            key_ready_q    <= 1'b0;
            result_valid_q <= 1'b0;
            st_q           <= '0;
        end else begin
            state_q        <= state_d;
            result_valid_q <= blk_done;
            if (init) begin
                klen_q      <= keylen;
                key_ready_q <= 1'b0;
                widx_q      <= keylen ? 6'd8 : 6'd4;
                if (keylen == KEYLEN_256)
                    for (int unsigned i = 0; i < 8; i++) w_q[i] <= key[255 - 32*i -: 32];
                else
                    for (int unsigned i = 0; i < 4; i++) w_q[i] <= key[127 - 32*i -: 32];
            end else if (state_q == CS_KEYEXP) begin
                w_q[widx_q] <= new_w;
                widx_q      <= widx_q + 6'd1;
                if (key_done) key_ready_q <= 1'b1;
            end
            if (start_blk) begin
                enc_q   <= encdec;
                st_q    <= block ^ rk;
                round_q <= encdec ? 4'd1 : nr - 4'd1;
            end else if (state_q == CS_ROUND && !init) begin
                st_q    <= round_out;
                round_q <= enc_q ? round_q + 4'd1 : round_q - 4'd1;
            end
        end
    end

    assign key_ready    = key_ready_q;
    assign result       = st_q;
    assign result_valid = result_valid_q;

endmodule

// File: rtl/aes_if.sv
// Byte-wide address-mapped host wrapper: config/key/block registers, start pulses, status and result readback.
module aes_if
    import aes_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  address,
    input  logic [15:0] data_in,
    output logic [7:0]  data_out
);

    logic [7:0]   data_out_q, data_out_d;
    logic [3:0]   prev_addr_q, cnt_q;
    logic         encdec_q, keylen_q, init_q, next_q;
    logic         ready_q, valid_q, busy_q, kr_q;
    logic [255:0] key_q;
    logic [127:0] block_q, result_q;

    logic         core_key_ready, core_result_valid, accept_next;
    logic [127:0] core_result;

    aes_core u_core (
        .clk          (clk),
        .rst_n        (rst_n),
        .encdec       (encdec_q),
        .keylen       (keylen_q),
        .init         (init_q),
        .next         (next_q),
        .key          (key_q),
        .block        (block_q),
        .key_ready    (core_key_ready),
        .result       (core_result),
        .result_valid (core_result_valid)
    );

    // Key readiness lives in the core, so a fresh next is accepted from the valid state too
    assign accept_next = next_q && core_key_ready && (!busy_q || core_result_valid);

    always_comb begin
        data_out_d = '0;
        case (address)
            ADDR_STATUS: begin
                data_out_d[STATUS_READY] = ready_q;
                data_out_d[STATUS_VALID] = valid_q;
            end
            ADDR_START:  data_out_d = {4'b0, keylen_q, encdec_q, next_q, init_q};
            ADDR_RESULT: data_out_d = result_q[8'd127 - {1'b0, cnt_q, 3'b000} -: 8];
            default:     data_out_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_out_q  <= '0;
            prev_addr_q <= ADDR_IDLE;
            cnt_q       <= '0;
            encdec_q    <= 1'b0;
            keylen_q    <= KEYLEN_128;
            init_q      <= 1'b0;
            next_q      <= 1'b0;
            ready_q     <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            kr_q        <= 1'b0;
            key_q       <= '0;
            block_q     <= '0;
            result_q    <= '0;
        end else begin
            prev_addr_q <= address;
            data_out_q  <= data_out_d;
            kr_q        <= core_key_ready;
            cnt_q       <= (address == ADDR_RESULT) ? cnt_q + 4'd1 : 4'd0;

            if (address == ADDR_CONFIG) begin
                encdec_q <= data_in[CONFIG_ENCDEC];
                keylen_q <= data_in[CONFIG_KEYLEN];
            end
            if (prev_addr_q == ADDR_KEY)   key_q   <= {key_q[239:0], data_in};
            if (prev_addr_q == ADDR_BLOCK) block_q <= {block_q[111:0], data_in};

            init_q <= 1'b0;
            next_q <= 1'b0;
            if (prev_addr_q == ADDR_START) begin
                init_q <= data_in[START_INIT];
                next_q <= data_in[START_NEXT] & ~data_in[START_INIT];
            end

            if (init_q) begin
                ready_q <= 1'b0;
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                if (core_key_ready && !kr_q) ready_q <= 1'b1;
                if (core_result_valid) begin
                    result_q <= core_result;
                    valid_q  <= 1'b1;
                    busy_q   <= 1'b0;
                end
                if (accept_next) begin
                    ready_q <= 1'b0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b1;
                end
            end
        end
    end

    assign data_out = data_out_q;

endmodule

// File: tb/tb_aes_if.sv
// Directed bench for aes_if: register map, start sequencing and FIPS-197 known-answer vectors.
module tb_aes_if;

    logic        clk;
    logic        rst_n;
    logic [3:0]  address;
    logic [15:0] data_in;
    logic [7:0]  data_out;

    int unsigned  checks = 0;
    int unsigned  errors = 0;
    logic [7:0]   rb [17];
    logic [127:0] res;
    logic [7:0]   st;
    logic         saw_valid;
    logic         saw_nonzero;

    aes_if dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .address  (address),
        .data_in  (data_in),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge clk);
            address = 4'd0;
            data_in = '0;
        end
    endtask

    task automatic cfg(input logic [15:0] v);
        @(negedge clk); address = 4'd1; data_in = v;
        @(negedge clk); address = 4'd0; data_in = '0;
    endtask

    task automatic start(input logic [15:0] v);
        @(negedge clk); address = 4'd6; data_in = v;
        @(negedge clk); address = 4'd0;
        @(negedge clk); data_in = '0;
    endtask

    task automatic write_words(input logic [3:0] a, input logic [255:0] val, input int unsigned n);
        @(negedge clk); address = a; data_in = '0;
        for (int unsigned k = 0; k < n; k++) begin
            @(negedge clk);
            data_in = val[16*(n-1-k) +: 16];
            if (k == n - 1) address = 4'd0;
        end
        @(negedge clk); data_in = '0;
    endtask

    task automatic wait_status(input logic [7:0] exp, input string tag);
        @(negedge clk); address = 4'd5;
        saw_valid = 1'b0;
        for (int unsigned i = 0; i < 300; i++) begin
            @(negedge clk);
            st = data_out;
            if (st[1]) saw_valid = 1'b1;
            if (st == exp) break;
        end
        address = 4'd0;
        check(tag, {120'b0, st}, {120'b0, exp});
    endtask

    task automatic read_result(input int unsigned n);
        @(negedge clk); address = 4'd7;
        for (int unsigned k = 0; k < n; k++) begin
            @(negedge clk);
            rb[k] = data_out;
        end
        address = 4'd0;
        for (int unsigned k = 0; k < 16; k++) res[127 - 8*k -: 8] = rb[k];
    endtask

    initial begin
        rst_n   = 1'b0;
        address = 4'd0;
        data_in = '0;
        repeat (3) @(negedge clk);
        check("reset_data_out", {120'b0, data_out}, 128'h0);
        rst_n = 1'b1;

        for (int unsigned i = 0; i < 5; i++) begin
            @(negedge clk); address = 4'd0; data_in = 16'hABCD;
        end
        @(negedge clk);
        check("idle_reads_zero", {120'b0, data_out}, 128'h0);
        data_in = '0;
        @(negedge clk); address = 4'd6;
        @(negedge clk);
        check("start_after_reset", {120'b0, data_out}, 128'h0);
        idle(2);

        // next with no key expanded must leave status clear
        start(16'h0002);
        @(negedge clk); address = 4'd5;
        saw_nonzero = 1'b0;
        for (int unsigned i = 0; i < 60; i++) begin
            @(negedge clk);
            if (data_out != 8'h00) saw_nonzero = 1'b1;
        end
        address = 4'd0;
        check("next_before_init", {127'b0, saw_nonzero}, 128'h0);

        @(negedge clk); address = 4'd1; data_in = 16'h0003;
        repeat (9) @(negedge clk);
        address = 4'd6; data_in = '0;
        @(negedge clk);
        check("config_readback", {120'b0, data_out}, 128'h0C);
        idle(2);

        write_words(4'd2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 16);
        start(16'h0001);
        wait_status(8'h01, "aes256_key_ready");
        write_words(4'd3, {128'h0, 128'h00112233445566778899aabbccddeeff}, 8);
        start(16'h0002);
        wait_status(8'h02, "aes256_valid");
        read_result(16);
        check("aes256_enc", res, 128'h8ea2b7ca516745bfeafc49904b496089);

        start(16'h0002);
        wait_status(8'h02, "renext_valid");
        read_result(16);
        check("renext_result", res, 128'h8ea2b7ca516745bfeafc49904b496089);

        read_result(17);
        check("result_wrap", {120'b0, rb[16]}, 128'h8e);

        start(16'h0002);
        start(16'h0001);
        wait_status(8'h01, "abort_ready");
        check("abort_no_valid", {127'b0, saw_valid}, 128'h0);

        cfg(16'h0001);
        write_words(4'd2, {128'h0, 128'h000102030405060708090a0b0c0d0e0f}, 8);
        start(16'h0001);
        wait_status(8'h01, "aes128_key_ready");
        write_words(4'd3, {128'h0, 128'h00112233445566778899aabbccddeeff}, 8);
        start(16'h0002);
        wait_status(8'h02, "aes128_valid");
        read_result(16);
        check("aes128_enc", res, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

        cfg(16'h0000);
        write_words(4'd3, {128'h0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a}, 8);
        start(16'h0002);
        wait_status(8'h02, "aes128_dec_valid");
        read_result(16);
        check("aes128_dec", res, 128'h00112233445566778899aabbccddeeff);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
